// File: rtl/fric_client_master_arb.sv
// Two-requester front end for one shared FRIC master: a one-deep slot per requester,
// alternating grant when both wait, and read-response routing with an abort timer.
module fric_client_master_arb #(
    parameter logic [7:0] RD_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  r0_type,
    input  logic [3:0]  r0_port,
    input  logic [7:0]  r0_addr,
    input  logic [15:0] r0_wdat,
    input  logic        r0_tstb,
    output logic        r0_trdy,
    output logic        r0_rstb,
    output logic [15:0] r0_rdat,
    input  logic [3:0]  r1_type,
    input  logic [3:0]  r1_port,
    input  logic [7:0]  r1_addr,
    input  logic [15:0] r1_wdat,
    input  logic        r1_tstb,
    output logic        r1_trdy,
    output logic        r1_rstb,
    output logic [15:0] r1_rdat,
    output logic [3:0]  master_type,
    output logic [3:0]  master_port,
    output logic [7:0]  master_addr,
    output logic [15:0] master_wdat,
    output logic        master_tstb,
    input  logic        master_trdy,
    input  logic        master_rstb,
    input  logic [15:0] master_rdat,
    output logic        rd_timeout
);

    localparam logic [1:0]  ST_IDLE      = 2'd0;
    localparam logic [1:0]  ST_ISSUE     = 2'd1;
    localparam logic [1:0]  ST_WAIT_RD   = 2'd2;
    localparam logic [3:0]  TYPE_READ    = 4'h1;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
    localparam logic [7:0]  TIMER_MAX    = 8'hFF;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        timer_q,      timer_d;

    logic [1:0]        slot_valid_q, slot_valid_d;
    logic [1:0][3:0]   slot_type_q,  slot_type_d;
    logic [1:0][3:0]   slot_port_q,  slot_port_d;
    logic [1:0][7:0]   slot_addr_q,  slot_addr_d;
    logic [1:0][15:0]  slot_wdat_q,  slot_wdat_d;

    logic [3:0]        master_type_q, master_type_d;
    logic [3:0]        master_port_q, master_port_d;
    logic [7:0]        master_addr_q, master_addr_d;
    logic [15:0]       master_wdat_q, master_wdat_d;
    logic              master_tstb_q, master_tstb_d;

    logic              r0_rstb_q,    r0_rstb_d;
    logic              r1_rstb_q,    r1_rstb_d;
    logic [15:0]       r0_rdat_q,    r0_rdat_d;
    logic [15:0]       r1_rdat_q,    r1_rdat_d;
    logic              rd_timeout_q, rd_timeout_d;

    logic              gnt_sel;
    logic              rsp_valid;
    logic [15:0]       rsp_data;

    // Slot capture, arbitration, issue sequencing and response routing.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        timer_d       = timer_q;
        slot_valid_d  = slot_valid_q;
        slot_type_d   = slot_type_q;
        slot_port_d   = slot_port_q;
        slot_addr_d   = slot_addr_q;
        slot_wdat_d   = slot_wdat_q;
        master_type_d = master_type_q;
        master_port_d = master_port_q;
        master_addr_d = master_addr_q;
        master_wdat_d = master_wdat_q;
        master_tstb_d = 1'b0;
        r0_rstb_d     = 1'b0;
        r1_rstb_d     = 1'b0;
        r0_rdat_d     = r0_rdat_q;
        r1_rdat_d     = r1_rdat_q;
        rd_timeout_d  = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = 16'h0000;
        // Both waiting: favour whoever was not served last; otherwise the only one.
        gnt_sel       = (&slot_valid_q) ? ~last_grant_q : slot_valid_q[1];

        if (r0_tstb && !slot_valid_q[0]) begin
            slot_valid_d[0] = 1'b1;
            slot_type_d[0]  = r0_type;
            slot_port_d[0]  = r0_port;
            slot_addr_d[0]  = r0_addr;
            slot_wdat_d[0]  = r0_wdat;
        end
        if (r1_tstb && !slot_valid_q[1]) begin
            slot_valid_d[1] = 1'b1;
            slot_type_d[1]  = r1_type;
            slot_port_d[1]  = r1_port;
            slot_addr_d[1]  = r1_addr;
            slot_wdat_d[1]  = r1_wdat;
        end

        case (state_q)
            ST_IDLE: begin
                if (master_trdy && (|slot_valid_q)) begin
                    master_type_d         = slot_type_q[gnt_sel];
                    master_port_d         = slot_port_q[gnt_sel];
                    master_addr_d         = slot_addr_q[gnt_sel];
                    master_wdat_d         = slot_wdat_q[gnt_sel];
                    master_tstb_d         = 1'b1;
                    slot_valid_d[gnt_sel] = 1'b0;
                    last_grant_d          = gnt_sel;
                    state_d               = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (master_type_q == TYPE_READ) begin
                    timer_d = 8'd0;
                    state_d = ST_WAIT_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                // A real response beats a simultaneous timeout.
                if (master_rstb) begin
                    rsp_valid = 1'b1;
                    rsp_data  = master_rdat;
                end else if (timer_q == RD_TIMEOUT) begin
                    rsp_valid    = 1'b1;
                    rsp_data     = TIMEOUT_DATA;
                    rd_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 8'(timer_q != TIMER_MAX);
                end
                if (rsp_valid) begin
                    state_d = ST_IDLE;
                    if (last_grant_q) begin
                        r1_rstb_d = 1'b1;
                        r1_rdat_d = rsp_data;
                    end else begin
                        r0_rstb_d = 1'b1;
                        r0_rdat_d = rsp_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            timer_q       <= 8'd0;
            slot_valid_q  <= 2'b00;
            slot_type_q   <= '0;
            slot_port_q   <= '0;
            slot_addr_q   <= '0;
            slot_wdat_q   <= '0;
            master_type_q <= 4'h0;
            master_port_q <= 4'h0;
            master_addr_q <= 8'h00;
            master_wdat_q <= 16'h0000;
            master_tstb_q <= 1'b0;
            r0_rstb_q     <= 1'b0;
            r1_rstb_q     <= 1'b0;
            r0_rdat_q     <= 16'h0000;
            r1_rdat_q     <= 16'h0000;
            rd_timeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            timer_q       <= timer_d;
            slot_valid_q  <= slot_valid_d;
            slot_type_q   <= slot_type_d;
            slot_port_q   <= slot_port_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdat_q   <= slot_wdat_d;
            master_type_q <= master_type_d;
            master_port_q <= master_port_d;
            master_addr_q <= master_addr_d;
            master_wdat_q <= master_wdat_d;
            master_tstb_q <= master_tstb_d;
            r0_rstb_q     <= r0_rstb_d;
            r1_rstb_q     <= r1_rstb_d;
            r0_rdat_q     <= r0_rdat_d;
            r1_rdat_q     <= r1_rdat_d;
            rd_timeout_q  <= rd_timeout_d;
        end
    end

    assign r0_trdy     = ~slot_valid_q[0];
    assign r1_trdy     = ~slot_valid_q[1];
    assign r0_rstb     = r0_rstb_q;
    assign r1_rstb     = r1_rstb_q;
    assign r0_rdat     = r0_rdat_q;
    assign r1_rdat     = r1_rdat_q;
    assign master_type = master_type_q;
    assign master_port = master_port_q;
    assign master_addr = master_addr_q;
    assign master_wdat = master_wdat_q;
    assign master_tstb = master_tstb_q;
    assign rd_timeout  = rd_timeout_q;

endmodule

// File: tb/tb_fric_client_master_arb.sv
// Scoreboard bench: a transaction-level model predicts master issues and read responses,
// a monitor pops and compares them whenever the DUT presents a strobe.
module tb_fric_client_master_arb;

    localparam logic [7:0] TO = 8'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  r0_type, r0_port, r1_type, r1_port;
    logic [7:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdat, r1_wdat;
    logic        r0_tstb, r1_tstb;
    logic        r0_trdy, r1_trdy, r0_rstb, r1_rstb;
    logic [15:0] r0_rdat, r1_rdat;
    logic [3:0]  master_type, master_port;
    logic [7:0]  master_addr;
    logic [15:0] master_wdat;
    logic        master_tstb, master_trdy, master_rstb;
    logic [15:0] master_rdat;
    logic        rd_timeout;

    always #5 clk = ~clk;

    fric_client_master_arb #(.RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_type(r0_type), .r0_port(r0_port), .r0_addr(r0_addr), .r0_wdat(r0_wdat),
        .r0_tstb(r0_tstb), .r0_trdy(r0_trdy), .r0_rstb(r0_rstb), .r0_rdat(r0_rdat),
        .r1_type(r1_type), .r1_port(r1_port), .r1_addr(r1_addr), .r1_wdat(r1_wdat),
        .r1_tstb(r1_tstb), .r1_trdy(r1_trdy), .r1_rstb(r1_rstb), .r1_rdat(r1_rdat),
        .master_type(master_type), .master_port(master_port), .master_addr(master_addr),
        .master_wdat(master_wdat), .master_tstb(master_tstb), .master_trdy(master_trdy),
        .master_rstb(master_rstb), .master_rdat(master_rdat), .rd_timeout(rd_timeout)
    );

    typedef struct { int cyc; logic [31:0] fields; } mexp_t;
    typedef struct { int cyc; int req; logic [15:0] dat; logic to; } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: pending requests per requester, a shared-master phase, and the
    // values every output should show in the following cycle.
    bit          m_pend[2];
    logic [31:0] m_req[2];
    logic [3:0]  m_rtype[2];
    int          m_phase;      // 0 free, 1 strobe cycle, 2 awaiting read data
    int          m_age, m_owner, m_last;
    logic [31:0] e_fields;
    logic [15:0] e_rdat[2];
    bit          take[2];
    logic        in_tstb[2];
    logic [31:0] in_req[2];
    logic [3:0]  in_type[2];
    int          g;

    always @(posedge clk) begin
        if (rst) begin
            m_pend[0] = 0; m_pend[1] = 0;
            m_phase = 0; m_age = 0; m_owner = 0; m_last = 1;
            e_fields = '0; e_rdat[0] = '0; e_rdat[1] = '0;
            mq.delete(); rq.delete();
        end else begin
            in_tstb[0] = r0_tstb; in_req[0] = {r0_type, r0_port, r0_addr, r0_wdat}; in_type[0] = r0_type;
            in_tstb[1] = r1_tstb; in_req[1] = {r1_type, r1_port, r1_addr, r1_wdat}; in_type[1] = r1_type;
            for (int i = 0; i < 2; i++) take[i] = in_tstb[i] && !m_pend[i];
            if (m_phase == 0) begin
                if (master_trdy && (m_pend[0] || m_pend[1])) begin
                    if (m_pend[0] && m_pend[1]) g = 1 - m_last;
                    else g = m_pend[0] ? 0 : 1;
                    mq.push_back('{cyc: cyc + 1, fields: m_req[g]});
                    e_fields  = m_req[g];
                    m_pend[g] = 0;
                    m_last    = g;
                    m_owner   = g;
                    m_phase   = (m_rtype[g] == 4'h1) ? 3 : 1;
                end
            end else if (m_phase == 1 || m_phase == 3) begin
                m_age   = 0;
                m_phase = (m_phase == 3) ? 2 : 0;
            end else begin
                if (master_rstb) begin
                    rq.push_back('{cyc: cyc + 1, req: m_owner, dat: master_rdat, to: 1'b0});
                    e_rdat[m_owner] = master_rdat;
                    m_phase = 0;
                end else if (m_age == int'(TO)) begin
                    rq.push_back('{cyc: cyc + 1, req: m_owner, dat: 16'hDEAD, to: 1'b1});
                    e_rdat[m_owner] = 16'hDEAD;
                    m_phase = 0;
                end else if (m_age < 255) begin
                    m_age++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (take[i]) begin
                    m_pend[i] = 1; m_req[i] = in_req[i]; m_rtype[i] = in_type[i];
                end
            end
        end
        cyc = cyc + 1;
    end

    // Monitor: compare every presented strobe against the scoreboard, plus held values.
    mexp_t me;
    rexp_t re;
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("r0_trdy", r0_trdy, !m_pend[0]);
            chk("r1_trdy", r1_trdy, !m_pend[1]);
            chk("master_fields", {master_type, master_port, master_addr, master_wdat}, e_fields);
            chk("r0_rdat", r0_rdat, e_rdat[0]);
            chk("r1_rdat", r1_rdat, e_rdat[1]);
            if (master_tstb) begin
                if (mq.size() == 0) chk("tstb_unexpected", master_tstb, 1'b0);
                else begin
                    me = mq.pop_front();
                    chk("tstb_cycle", cyc, me.cyc);
                    chk("tstb_fields", {master_type, master_port, master_addr, master_wdat}, me.fields);
                end
            end else if (mq.size() > 0 && mq[0].cyc <= cyc) begin
                chk("tstb_missing", master_tstb, 1'b1);
                void'(mq.pop_front());
            end
            if (r0_rstb || r1_rstb) begin
                if (rq.size() == 0) chk("rstb_unexpected", {r1_rstb, r0_rstb}, 2'b00);
                else begin
                    re = rq.pop_front();
                    chk("rsp_cycle", cyc, re.cyc);
                    chk("rsp_who", {r1_rstb, r0_rstb}, (re.req == 1) ? 2'b10 : 2'b01);
                    chk("rsp_data", (re.req == 1) ? r1_rdat : r0_rdat, re.dat);
                    chk("rsp_timeout", rd_timeout, re.to);
                end
            end else begin
                if (rd_timeout) chk("timeout_without_rstb", rd_timeout, 1'b0);
                if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                    chk("rsp_missing", {r1_rstb, r0_rstb}, (rq[0].req == 1) ? 2'b10 : 2'b01);
                    void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic quiet();
        r0_tstb = 0; r1_tstb = 0; master_rstb = 0;
    endtask

    int lat;
    bit seen;

    initial begin
        rst = 1; master_trdy = 0; master_rdat = 0;
        r0_type = 0; r0_port = 0; r0_addr = 0; r0_wdat = 0;
        r1_type = 0; r1_port = 0; r1_addr = 0; r1_wdat = 0;
        quiet();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_tstb", master_tstb, 1'b0);
        chk("reset_trdy", {r1_trdy, r0_trdy}, 2'b11);

        // Single write: strobe cycle k, slot busy in k+1, issue in k+2.
        r0_type = 4'h0; r0_port = 4'h3; r0_addr = 8'h12; r0_wdat = 16'hBEEF; r0_tstb = 1; master_trdy = 1;
        @(negedge clk); r0_tstb = 0;
        chk("d1_trdy_c1", r0_trdy, 1'b0);
        chk("d1_tstb_c1", master_tstb, 1'b0);
        @(negedge clk);
        chk("d1_tstb_c2", master_tstb, 1'b1);
        chk("d1_fields", {master_type, master_port, master_addr, master_wdat}, 32'h0312BEEF);
        chk("d1_trdy_c2", r0_trdy, 1'b1);
        @(negedge clk);
        chk("d1_tstb_c3", master_tstb, 1'b0);

        // Read by r1 answered three cycles after the issue strobe.
        r1_type = 4'h1; r1_port = 4'h2; r1_addr = 8'h40; r1_wdat = 16'h0; r1_tstb = 1;
        @(negedge clk); r1_tstb = 0;
        @(negedge clk);
        chk("d2_tstb", master_tstb, 1'b1);
        chk("d2_addr", master_addr, 8'h40);
        repeat (3) @(negedge clk);
        master_rstb = 1; master_rdat = 16'h1234;
        @(negedge clk); master_rstb = 0;
        chk("d2_r1_rstb", r1_rstb, 1'b1);
        chk("d2_r1_rdat", r1_rdat, 16'h1234);
        chk("d2_r0_rstb", r0_rstb, 1'b0);
        @(negedge clk);
        chk("d2_r1_rstb_off", r1_rstb, 1'b0);

        // Simultaneous writes, twice; the scoreboard fixes the r0,r1,r0,r1 order.
        for (int rep = 0; rep < 2; rep++) begin
            r0_type = 4'h0; r0_port = 4'h6; r0_addr = 8'(8'h10 + rep); r0_wdat = 16'(16'hA000 + rep);
            r1_type = 4'h2; r1_port = 4'h7; r1_addr = 8'(8'h20 + rep); r1_wdat = 16'(16'hB000 + rep);
            r0_tstb = 1; r1_tstb = 1;
            @(negedge clk); quiet();
            repeat (6) @(negedge clk);
        end

        // Read with no response: aborted after TO+1 waiting cycles.
        r0_type = 4'h1; r0_port = 4'h1; r0_addr = 8'h77; r0_tstb = 1; lat = 0;
        do begin
            @(negedge clk); r0_tstb = 0; lat++;
        end while (!r0_rstb && lat < 20);
        chk("d4_latency", lat, 8);
        chk("d4_rdat", r0_rdat, 16'hDEAD);
        chk("d4_timeout", rd_timeout, 1'b1);
        master_rstb = 1; master_rdat = 16'h5555;
        @(negedge clk); master_rstb = 0;
        chk("d4_timeout_off", rd_timeout, 1'b0);
        @(negedge clk);
        chk("d4_late_rstb", r0_rstb, 1'b0);
        chk("d4_rdat_hold", r0_rdat, 16'hDEAD);

        // Master stalled with both slots full, then released after a fresh reset.
        rst = 1; @(negedge clk); rst = 0; master_trdy = 0;
        r0_type = 4'h0; r0_port = 4'h5; r1_type = 4'h0; r1_port = 4'h9;
        r0_tstb = 1; r1_tstb = 1;
        @(negedge clk); quiet();
        repeat (3) begin
            @(negedge clk);
            chk("d5_stall_tstb", master_tstb, 1'b0);
            chk("d5_stall_trdy", {r1_trdy, r0_trdy}, 2'b00);
        end
        master_trdy = 1; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (master_tstb) begin
                seen = 1;
                chk("d5_first_port", master_port, 4'h5);
            end
        end
        if (!seen) chk("d5_tstb_seen", master_tstb, 1'b1);
        repeat (6) @(negedge clk);

        // Reset while a read is outstanding: nothing is returned.
        r1_type = 4'h1; r1_port = 4'h4; r1_addr = 8'h41; r1_tstb = 1;
        @(negedge clk); quiet();
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0;
        chk("d6_zero_fields", {master_type, master_port, master_addr, master_wdat}, 32'h0);
        chk("d6_zero_rstb", {r1_rstb, r0_rstb, rd_timeout, master_tstb}, 4'h0);
        master_rstb = 1; master_rdat = 16'h9999;
        @(negedge clk); master_rstb = 0;
        chk("d6_no_rstb", {r1_rstb, r0_rstb}, 2'b00);
        chk("d6_trdy", {r1_trdy, r0_trdy}, 2'b11);
        chk("d6_r1_rdat", r1_rdat, 16'h0000);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r0_tstb = ($urandom_range(0, 2) == 0);
            r1_tstb = ($urandom_range(0, 2) == 0);
            r0_type = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom_range(0, 15));
            r1_type = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom_range(0, 15));
            r0_port = 4'($urandom_range(0, 15)); r1_port = 4'($urandom_range(0, 15));
            r0_addr = 8'($urandom_range(0, 255)); r1_addr = 8'($urandom_range(0, 255));
            r0_wdat = 16'($urandom_range(0, 65535)); r1_wdat = 16'($urandom_range(0, 65535));
            master_trdy = ($urandom_range(0, 3) != 0);
            master_rstb = ($urandom_range(0, 5) == 0);
            master_rdat = 16'($urandom_range(0, 65535));
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk); quiet(); rst = 0;
        repeat (20) @(negedge clk);
        chk("mq_drained", mq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
